// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, special
// instruction words and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int INSTR_WIDTH = 20;
    localparam int PC_BITS     = 5;
    localparam int ROM_DEPTH   = 2 ** PC_BITS;

    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [PC_BITS-1:0]     pc_t;

    localparam instr_t NOP_WORD  = 20'h00000;
    localparam instr_t HALT_WORD = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic logic is_halt_word(instr_t word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of program-load, control and instruction-output signals between
// the fetch stage (slave) and whatever drives it (master).
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic   prog_wen;
    pc_t    prog_addr;
    instr_t prog_data;
    logic   run;
    logic   stall;
    logic   branch_en;
    pc_t    branch_target;
    instr_t instruction;
    logic   instr_valid;
    pc_t    instr_pc;
    logic   halted;

    modport master (
        output prog_wen, prog_addr, prog_data,
        output run, stall, branch_en, branch_target,
        input  instruction, instr_valid, instr_pc, halted
    );

    modport slave (
        input  prog_wen, prog_addr, prog_data,
        input  run, stall, branch_en, branch_target,
        output instruction, instr_valid, instr_pc, halted
    );

endinterface

// File: rtl/instr_fetch_rom.sv
// Program store: synchronous write, combinational read, one word per address.
module instr_rom
    import instr_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   wen,
    input  pc_t    waddr,
    input  instr_t wdata,
    input  pc_t    raddr,
    output instr_t rdata
);

    instr_t mem [ROM_DEPTH];

    // Store write; contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program store plus a pc-stepping FSM that
// presents one registered instruction word per cycle to the CPU, with
// stall, branch flush and a halt word that parks the stage.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);

    fetch_state_t state;
    pc_t          pc;
    instr_t       instruction_q;
    logic         instr_valid_q;
    pc_t          instr_pc_q;
    logic         halted_q;

    instr_t rom_rdata;
    logic   rom_wen;

    // Loading is only allowed while idle, and a coincident reset suppresses it.
    assign rom_wen = bus.prog_wen && (state == IDLE) && !rst;

    instr_rom u_rom (
        .clk   (clk),
        .wen   (rom_wen),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc),
        .rdata (rom_rdata)
    );

    // Fetch FSM with pc and registered outputs; branch beats stall, stall beats fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= '0;
            instruction_q <= NOP_WORD;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state <= FETCH;
                        pc    <= '0;
                    end
                end
                FETCH: begin
                    if (bus.branch_en) begin
                        pc            <= bus.branch_target;
                        instruction_q <= NOP_WORD;
                        instr_valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        if (is_halt_word(rom_rdata)) begin
                            instruction_q <= NOP_WORD;
                            instr_valid_q <= 1'b0;
                            halted_q      <= 1'b1;
                            state         <= HALT;
                        end else begin
                            instruction_q <= rom_rdata;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                            pc            <= pc + pc_t'(1);
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch: load, sequential fetch,
// stall, branch flush, wrap, mid-run reset, halt freeze and store retention.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    typedef struct {
        string  name;
        logic   rst;
        logic   run;
        logic   stall;
        logic   branch_en;
        pc_t    target;
        logic   wen;
        pc_t    waddr;
        instr_t wdata;
        instr_t exp_instr;
        logic   exp_valid;
        pc_t    exp_pc;
        logic   chk_pc;
        logic   exp_halted;
    } vec_t;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    vec_t vecs [$];

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string name, logic r, logic rn, logic st, logic br,
                                pc_t tg, logic we, pc_t wa, instr_t wd,
                                instr_t ei, logic ev, pc_t ep, logic cp, logic eh);
        vec_t v;
        v.name = name; v.rst = r; v.run = rn; v.stall = st; v.branch_en = br;
        v.target = tg; v.wen = we; v.waddr = wa; v.wdata = wd;
        v.exp_instr = ei; v.exp_valid = ev; v.exp_pc = ep; v.chk_pc = cp;
        v.exp_halted = eh;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic rn, input logic st,
                                 input logic br, input pc_t tg, input logic we,
                                 input pc_t wa, input instr_t wd);
        @(negedge clk);
        rst               = r;
        bus.run           = rn;
        bus.stall         = st;
        bus.branch_en     = br;
        bus.branch_target = tg;
        bus.prog_wen      = we;
        bus.prog_addr     = wa;
        bus.prog_data     = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic checkOutput(input string name, input instr_t ei, input logic ev,
                               input pc_t ep, input logic cp, input logic eh);
        checkField(name, "instruction", 32'(bus.instruction), 32'(ei));
        checkField(name, "instr_valid", 32'(bus.instr_valid), 32'(ev));
        checkField(name, "halted",      32'(bus.halted),      32'(eh));
        if (cp) begin
            checkField(name, "instr_pc", 32'(bus.instr_pc), 32'(ep));
        end
    endtask

    initial begin
        pass_cnt          = 0;
        total_cnt         = 0;
        rst               = 1'b1;
        bus.run           = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_en     = 1'b0;
        bus.branch_target = '0;
        bus.prog_wen      = 1'b0;
        bus.prog_addr     = '0;
        bus.prog_data     = '0;

        // Reset, then preload every address with a known 20'hA00xx pattern.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < ROM_DEPTH; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, pc_t'(i), 20'hA0000 | 20'(i));
        end
        checkOutput("idle_after_load", NOP_WORD, 0, 0, 1, 0);

        //                name          rst run st br tgt wen wa  wdata      exp_instr  v  pc cp h
        vecs.push_back(mk("reset",       1, 0, 0, 0, 0,  0, 0,  20'h0,     NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("load0",       0, 0, 0, 0, 0,  1, 0,  20'h12345, NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("load1",       0, 0, 0, 0, 0,  1, 1,  20'h0ABCD, NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("load31",      0, 0, 0, 0, 0,  1, 31, 20'h31111, NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("run",         0, 1, 0, 0, 0,  0, 0,  20'h0,     NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("fetch0",      0, 0, 0, 0, 0,  0, 0,  20'h0,     20'h12345, 1, 0, 1, 0));
        vecs.push_back(mk("fetch1",      0, 0, 0, 0, 0,  0, 0,  20'h0,     20'h0ABCD, 1, 1, 1, 0));
        vecs.push_back(mk("fetch2",      0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA0002, 1, 2, 1, 0));
        vecs.push_back(mk("fetch3",      0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA0003, 1, 3, 1, 0));
        vecs.push_back(mk("fetch4",      0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA0004, 1, 4, 1, 0));
        vecs.push_back(mk("stall1",      0, 0, 1, 0, 0,  0, 0,  20'h0,     20'hA0004, 1, 4, 1, 0));
        vecs.push_back(mk("stall2",      0, 0, 1, 0, 0,  0, 0,  20'h0,     20'hA0004, 1, 4, 1, 0));
        vecs.push_back(mk("stall3",      0, 0, 1, 0, 0,  0, 0,  20'h0,     20'hA0004, 1, 4, 1, 0));
        vecs.push_back(mk("release",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA0005, 1, 5, 1, 0));
        vecs.push_back(mk("br_stall",    0, 0, 1, 1, 2,  0, 0,  20'h0,     NOP_WORD,  0, 0, 0, 0));
        vecs.push_back(mk("target2",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA0002, 1, 2, 1, 0));
        vecs.push_back(mk("br30",        0, 0, 0, 1, 30, 0, 0,  20'h0,     NOP_WORD,  0, 0, 0, 0));
        vecs.push_back(mk("fetch30",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA001E, 1, 30,1, 0));
        vecs.push_back(mk("fetch31",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'h31111, 1, 31,1, 0));
        vecs.push_back(mk("wrap0",       0, 0, 0, 0, 0,  1, 5,  20'h77777, 20'h12345, 1, 0, 1, 0));
        vecs.push_back(mk("rst_mid",     1, 1, 0, 0, 0,  0, 0,  20'h0,     NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("idle_load3",  0, 0, 0, 0, 0,  1, 3,  20'hFFFFF, NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("run_write0",  0, 1, 0, 0, 0,  1, 0,  20'h00001, NOP_WORD,  0, 0, 1, 0));
        vecs.push_back(mk("hfetch0",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'h00001, 1, 0, 1, 0));
        vecs.push_back(mk("hfetch1",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'h0ABCD, 1, 1, 1, 0));
        vecs.push_back(mk("hfetch2",     0, 0, 0, 0, 0,  0, 0,  20'h0,     20'hA0002, 1, 2, 1, 0));
        vecs.push_back(mk("halt_entry",  0, 0, 0, 0, 0,  0, 0,  20'h0,     NOP_WORD,  0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].stall, vecs[i].branch_en,
                          vecs[i].target, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
            checkOutput(vecs[i].name, vecs[i].exp_instr, vecs[i].exp_valid,
                        vecs[i].exp_pc, vecs[i].chk_pc, vecs[i].exp_halted);
        end

        // Parked in HALT: run, branch and store writes must all be ignored.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 1, 7, 1, 0, 20'h55555);
            checkOutput("halt_frozen", NOP_WORD, 0, 0, 0, 1);
        end

        // Reset out of HALT, remove the halt word, rerun and confirm the
        // writes attempted during FETCH and HALT never reached the store.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_reset", NOP_WORD, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 20'hA0003);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("rerun_start", NOP_WORD, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retain0", 20'h00001, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retain1", 20'h0ABCD, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retain2", 20'hA0002, 1, 2, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retain3", 20'hA0003, 1, 3, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retain4", 20'hA0004, 1, 4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retain5", 20'hA0005, 1, 5, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of `simple_cpu`. It holds a 32-entry program store loaded over a write port, and steps a program counter through it. Each fetched 20-bit word is presented on the `instruction` input of the CPU one word per cycle. It supports stall, branch redirect with a one-cycle flush, and a halt word that parks the stage.

## Interface
- `INSTR_WIDTH`, 20, instruction word width; matches the CPU instruction input.
- `PC_BITS`, 5, program-counter width; store depth is 2^PC_BITS = 32 words.
- `NOP_WORD`, 20'h00000, bubble word driven when no valid instruction is presented.
- `HALT_WORD`, 20'hFFFFF, fetched word that stops fetching.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_wen`  in  1  program-store write enable; honoured only in IDLE.
- `prog_addr`  in  PC_BITS  program-store write address.
- `prog_data`  in  INSTR_WIDTH  program-store write data.
- `run`  in  1  starts fetching from address 0 when sampled high in IDLE.
- `stall`  in  1  freezes the stage while high.
- `branch_en`  in  1  redirects fetch to `branch_target`.
- `branch_target`  in  PC_BITS  redirect address.
- `instruction`  out  INSTR_WIDTH  registered word to CPU; NOP_WORD when invalid.
- `instr_valid`  out  1  `instruction` is a real fetched word.
- `instr_pc`  out  PC_BITS  address the current `instruction` came from.
- `halted`  out  1  high while in HALT.

## Operation
- FSM states: IDLE, FETCH, HALT.
- Reset sets state=IDLE, pc=0, `instruction`=NOP_WORD, `instr_valid`=0, `instr_pc`=0, `halted`=0. The program store is not cleared.
- **IDLE**
  - `prog_wen`=1 writes `mem[prog_addr] <= prog_data`.
  - `run`=1 moves to FETCH with pc=0. A write and `run` in the same cycle both take effect.
  - Outputs hold their reset values.
- **FETCH**, per cycle, in priority order:
  1. `branch_en`=1: pc <= `branch_target`; `instruction` <= NOP_WORD; `instr_valid` <= 0 (flush). This overrides `stall`.
  2. `stall`=1: pc, `instruction`, `instr_valid` and `instr_pc` all hold.
  3. `mem[pc]` == HALT_WORD: `instruction` <= NOP_WORD; `instr_valid` <= 0; `halted` <= 1; go to HALT. pc holds at the halt address.
  4. Otherwise: `instruction` <= `mem[pc]`; `instr_pc` <= pc; `instr_valid` <= 1; pc <= pc+1, wrapping modulo 2^PC_BITS (31 -> 0).
- **HALT**: outputs frozen with `instr_valid`=0 and `halted`=1. Only `rst` exits HALT. `run`, `branch_en` and `prog_wen` are ignored.
- `prog_wen` in FETCH or HALT is ignored; the store is never modified.

## Timing
- Fetch latency is 1 cycle. pc=k sampled at edge t gives `instruction`=mem[k] valid after edge t.
- In steady state, one word per cycle.
- The first valid word appears 2 edges after `run` is sampled: IDLE->FETCH, then the first fetch.
- A store write at edge t is readable by a fetch at edge t+1 or later.
- Branch costs one bubble cycle. The target word is valid on the edge after the flush edge.
- `rst` asserted in any state, including mid-stall or mid-branch, takes effect at the next edge and wins over all other inputs.

## Structure
- The shared package holds the state encoding (IDLE, FETCH, HALT), NOP_WORD, HALT_WORD and the default widths. The CPU top and the CU reuse the same instruction width.
- One natural sub-module: `instr_rom`, a synchronous-write, combinational-read 32 x 20 store with `clk`, `wen`, `waddr`, `wdata`, `raddr` and `rdata`.
- The FSM, pc and output registers live in `instr_fetch`.

## Test plan
- **Reset and load:** reset, write 20'h12345 to addr 0 and 20'h0ABCD to addr 1, pulse `run`. Expect `instruction`=20'h12345 with `instr_pc`=0, then 20'h0ABCD with `instr_pc`=1, `instr_valid`=1 on each.
- **Wrap:** load addr 31 with 20'h31111 and addr 0 with 20'h00001, then branch to 30. After the bubble, expect words from addr 30, 31, then 0, with `instr_pc` 30 -> 31 -> 0.
- **Stall:** assert `stall` for 3 cycles while `instruction`=mem[4]. Expect `instruction`, `instr_pc`=4 and `instr_valid` to hold. Expect mem[5] on the first edge after release.
- **Branch plus stall together:** at pc=6, assert `branch_en` with target 2 and `stall` together. Expect one NOP_WORD with `instr_valid`=0, then mem[2] with `instr_pc`=2.
- **Halt:** place 20'hFFFFF at addr 3. Expect words 0..2 valid, then NOP_WORD with `instr_valid`=0 and `halted`=1, frozen for 10 cycles. `prog_wen` to addr 0 during HALT leaves mem[0] unchanged after reset and rerun.
- **Reset mid-run:** assert `rst` during FETCH. After the edge, expect IDLE with all outputs at reset values, and the program store contents retained.
